ag32gbd_ram_read: RTL and testbench
===================================

Name: ag32gbd_ram_read

Overview:
- Reads one 256-byte block of SRAM bank0 at {round_cnt[3:0], offset[7:0]}.
- Re-interleaves each RAM byte pair back into packed 2bpp buffer bytes (MSB = leftmost pixel) and writes them into the 1 KiB block buffer.
- Counterpart of the bank0 SRAM writer. Used to read back a captured picture 8 rows at a time: 16 rounds give 128 rows.

Parameters:
- HEAT_UP_CYCLES, 10, cycles nCS is held low before the first address is driven.
- READ_WAIT_CYCLES, 5, cycles from address change to sampling Ram_Reading_Data (covers tAA plus pad trace).

Ports:
- sys_clock  in  1  system clock; single clock domain.
- sys_resetn  in  1  reset, synchronous, active-low.
- NewRunReset  in  1  synchronous clear of the block and the round counter.
- BlockReadRequest  in  1  level from sequencer; a rising edge starts one block read.
- Gbd_Reading_Ram  out  1  high while the block owns the SRAM bus (HEAT_UP through last buffer write).
- Ram_Reading_Addr_Low  out  12  SRAM address {round_cnt, offset}.
- Ram_Reading_nCS  out  1  SRAM chip enable, active-low.
- Ram_Reading_nOE  out  1  SRAM output enable, active-low.
- Ram_Reading_Data  in  8  SRAM data bus.
- WriteBuffer  out  1  buffer write request, 4-phase.
- WriteBufferOffset  out  10  buffer byte offset.
- WriteBufferData  out  8  buffer byte.
- BufferWriteAck  in  1  buffer acknowledge, 4-phase.
- BlockDone  out  1  one-cycle pulse when a block completes.
- RoundCount  out  4  current round_cnt.

Behaviour:
- Reset: sync; sys_resetn low or NewRunReset high at a clock edge sets:
  - State=IDLE, round_cnt=0, pair index k=0;
  - Addr=0, nCS=1, nOE=1;
  - WriteBuffer=0, offset=0, data=0;
  - BlockDone=0, Gbd_Reading_Ram=0.
  - Reset wins over a simultaneous trigger.
  - Reset mid-block aborts immediately; nCS and nOE are high on the next cycle.
- Trigger:
  - BlockReadRequest is registered once.
  - Start = registered 0 and current 1, seen in IDLE only. Edges while busy are ignored and not queued.
- States:
  - IDLE: on start, k=0, nCS=0, go to HEAT_UP.
  - HEAT_UP: wait HEAT_UP_CYCLES, then nOE=0 and go to ADDR0.
  - ADDR0: Addr={round_cnt, k, 1'b0}; go to SAMPLE0.
  - SAMPLE0: wait READ_WAIT_CYCLES, latch p0=Ram_Reading_Data, go to ADDR1.
  - ADDR1: Addr={round_cnt, k, 1'b1}; go to SAMPLE1.
  - SAMPLE1: wait READ_WAIT_CYCLES, latch p1, go to WBUF0.
  - WBUF0:
    - Drive offset={2'b0, k[2:0], k[6:3], 1'b0} and data b0={p1[7],p0[7],p1[6],p0[6],p1[5],p0[5],p1[4],p0[4]}.
    - Assert WriteBuffer.
    - On Ack=1, drop WriteBuffer; on Ack=0 afterwards, go to WBUF1.
    - Offset and data are stable from request until Ack is seen.
  - WBUF1:
    - Same handshake with offset low bit=1 and b1={p1[3],p0[3],p1[2],p0[2],p1[1],p0[1],p1[0],p0[0]}.
    - Then go to NEXT.
  - NEXT:
    - If k==127: nCS=1, nOE=1, Addr=0, round_cnt+1 (wraps F→0), BlockDone pulse, go to IDLE.
    - Otherwise k+1 and go to ADDR0.
- Mapping: this is the exact inverse of the writer.
  - RAM[2k] holds the even bits of both buffer bytes; RAM[2k+1] holds the odd bits.
  - k[2:0] is iy (inner loop), k[6:3] is ix/2.
- nOE stays low for the whole block; the block never drives the SRAM data bus.
- The waits apply per address, so the address is stable ≥ READ_WAIT_CYCLES before each sample.
- Gbd_Reading_Ram = (State != IDLE).
- round_cnt is not cleared by a new trigger, only by reset/NewRunReset.
- Block length is 256 SRAM reads and 256 buffer writes.

Test Plan:
- Reset then single trigger; SRAM model RAM[000]=0xF0, RAM[001]=0x0F; immediate Ack → first writes are off 0x000 = 0x55 and off 0x001 = 0xAA. nCS falls 1 cycle after the edge; the first address appears after 10 cycles.
- Full block with a RAM model encoding the writer's pattern from a known buffer image → all 256 buffer bytes match the original image; BlockDone pulses once; RoundCount 0→1.
- 16 consecutive triggers → addresses span 0x000–0xFFF; after the 16th, RoundCount=0 (wrap).
- Ack delayed 7 cycles and held 3 → WriteBuffer, offset and data stable throughout; no SRAM address change during the handshake.
- Second BlockReadRequest edge at pair k=40 → ignored; the block completes normally with a single BlockDone.
- NewRunReset asserted at k=60, also simultaneously with a fresh trigger edge → next cycle: IDLE, nCS=1, nOE=1, WriteBuffer=0, RoundCount=0, no BlockDone; the trigger is ignored.

Source files
------------

// File: rtl/ag32gbd_ram_read_if.sv
// SRAM bank0 read bus and 4-phase block-buffer write handshake.
// The master side is the block reader; the slave side is the SRAM plus buffer.
interface ag32gbd_ram_read_if;
  logic [11:0] Ram_Reading_Addr_Low;
  logic        Ram_Reading_nCS;
  logic        Ram_Reading_nOE;
  logic [7:0]  Ram_Reading_Data;
  logic        WriteBuffer;
  logic [9:0]  WriteBufferOffset;
  logic [7:0]  WriteBufferData;
  logic        BufferWriteAck;

  modport master (
    output Ram_Reading_Addr_Low, Ram_Reading_nCS, Ram_Reading_nOE,
    output WriteBuffer, WriteBufferOffset, WriteBufferData,
    input  Ram_Reading_Data, BufferWriteAck
  );

  modport slave (
    input  Ram_Reading_Addr_Low, Ram_Reading_nCS, Ram_Reading_nOE,
    input  WriteBuffer, WriteBufferOffset, WriteBufferData,
    output Ram_Reading_Data, BufferWriteAck
  );
endinterface

// File: rtl/ag32gbd_ram_read.sv
// Reads one 256-byte SRAM bank0 block per trigger and re-interleaves each byte
// pair into two packed 2bpp bytes written to the block buffer.
module ag32gbd_ram_read #(
  parameter int unsigned HEAT_UP_CYCLES   = 10,
  parameter int unsigned READ_WAIT_CYCLES = 5
) (
  input  logic                      sys_clock,
  input  logic                      sys_resetn,
  input  logic                      NewRunReset,
  input  logic                      BlockReadRequest,
  output logic                      Gbd_Reading_Ram,
  ag32gbd_ram_read_if.master        bus,
  output logic                      BlockDone,
  output logic [3:0]                RoundCount
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HEAT_LAST = CNT_W'(HEAT_UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, HEAT_UP, ADDR0, SAMPLE0, ADDR1, SAMPLE1, WBUF0, WBUF1, NEXT
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [6:0]       k, k_n;
  logic [3:0]       round_cnt, round_n;
  logic [7:0]       p0, p0_n;
  logic [3:0]       p1_lo, p1_lo_n;
  logic [11:0]      addr, addr_n;
  logic             ncs, ncs_n;
  logic             noe, noe_n;
  logic             wb, wb_n;
  logic [9:0]       wb_off, wb_off_n;
  logic [7:0]       wb_data, wb_data_n;
  logic             ack_seen, ack_seen_n;
  logic             done, done_n;
  logic             busy, busy_n;
  logic             req_q;
  logic             start_c;

  // Interleave two nibbles into one 2bpp byte: odd bit above even bit per pixel.
  function automatic logic [7:0] weave(input logic [3:0] odd, input logic [3:0] even);
    logic [7:0] w;
    for (int i = 0; i < 4; i++) begin
      w[2*i+1] = odd[i];
      w[2*i]   = even[i];
    end
    return w;
  endfunction

  // Trigger edge detector keeps sampling through reset so a held level cannot retrigger.
  always_ff @(posedge sys_clock) req_q <= BlockReadRequest;

  assign start_c = !req_q && BlockReadRequest;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    k_n        = k;
    round_n    = round_cnt;
    p0_n       = p0;
    p1_lo_n    = p1_lo;
    addr_n     = addr;
    ncs_n      = ncs;
    noe_n      = noe;
    wb_n       = wb;
    wb_off_n   = wb_off;
    wb_data_n  = wb_data;
    ack_seen_n = ack_seen;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        if (start_c) begin
          k_n     = 7'd0;
          cnt_n   = '0;
          ncs_n   = 1'b0;
          state_n = HEAT_UP;
        end
      end
      HEAT_UP: begin
        if (cnt == HEAT_LAST) begin
          noe_n   = 1'b0;
          state_n = ADDR0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ADDR0: begin
        addr_n  = {round_cnt, k, 1'b0};
        cnt_n   = '0;
        state_n = SAMPLE0;
      end
      SAMPLE0: begin
        if (cnt == WAIT_LAST) begin
          p0_n    = bus.Ram_Reading_Data;
          state_n = ADDR1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ADDR1: begin
        addr_n  = {round_cnt, k, 1'b1};
        cnt_n   = '0;
        state_n = SAMPLE1;
      end
      SAMPLE1: begin
        if (cnt == WAIT_LAST) begin
          // Only the low nibble of p1 is needed later; the high nibble goes straight into b0.
          p1_lo_n    = bus.Ram_Reading_Data[3:0];
          wb_off_n   = {2'b00, k[2:0], k[6:3], 1'b0};
          wb_data_n  = weave(bus.Ram_Reading_Data[7:4], p0[7:4]);
          wb_n       = 1'b1;
          ack_seen_n = 1'b0;
          state_n    = WBUF0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WBUF0: begin
        if (!ack_seen) begin
          if (bus.BufferWriteAck) begin
            wb_n       = 1'b0;
            ack_seen_n = 1'b1;
          end
        end else if (!bus.BufferWriteAck) begin
          wb_off_n   = {2'b00, k[2:0], k[6:3], 1'b1};
          wb_data_n  = weave(p1_lo, p0[3:0]);
          wb_n       = 1'b1;
          ack_seen_n = 1'b0;
          state_n    = WBUF1;
        end
      end
      WBUF1: begin
        if (!ack_seen) begin
          if (bus.BufferWriteAck) begin
            wb_n       = 1'b0;
            ack_seen_n = 1'b1;
          end
        end else if (!bus.BufferWriteAck) begin
          ack_seen_n = 1'b0;
          state_n    = NEXT;
        end
      end
      NEXT: begin
        if (k == 7'd127) begin
          ncs_n   = 1'b1;
          noe_n   = 1'b1;
          addr_n  = '0;
          round_n = round_cnt + 4'd1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          k_n     = k + 7'd1;
          state_n = ADDR0;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and registered outputs; NewRunReset aborts exactly like a reset.
  always_ff @(posedge sys_clock) begin
    if (!sys_resetn || NewRunReset) begin
      state     <= IDLE;
      cnt       <= '0;
      k         <= '0;
      round_cnt <= '0;
      p0        <= '0;
      p1_lo     <= '0;
      addr      <= '0;
      ncs       <= 1'b1;
      noe       <= 1'b1;
      wb        <= 1'b0;
      wb_off    <= '0;
      wb_data   <= '0;
      ack_seen  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      k         <= k_n;
      round_cnt <= round_n;
      p0        <= p0_n;
      p1_lo     <= p1_lo_n;
      addr      <= addr_n;
      ncs       <= ncs_n;
      noe       <= noe_n;
      wb        <= wb_n;
      wb_off    <= wb_off_n;
      wb_data   <= wb_data_n;
      ack_seen  <= ack_seen_n;
      done      <= done_n;
      busy      <= busy_n;
    end
  end

  assign bus.Ram_Reading_Addr_Low = addr;
  assign bus.Ram_Reading_nCS      = ncs;
  assign bus.Ram_Reading_nOE      = noe;
  assign bus.WriteBuffer          = wb;
  assign bus.WriteBufferOffset    = wb_off;
  assign bus.WriteBufferData      = wb_data;
  assign Gbd_Reading_Ram          = busy;
  assign BlockDone                = done;
  assign RoundCount               = round_cnt;

endmodule

// File: tb/tb_ag32gbd_ram_read.sv
// Bench for ag32gbd_ram_read: SRAM image built from known buffer images with the
// writer's bit split, expected buffer writes queued at trigger time.
module tb_ag32gbd_ram_read;
  localparam int unsigned HEAT = 10;

  logic       sys_clock = 1'b0;
  logic       sys_resetn;
  logic       NewRunReset;
  logic       BlockReadRequest;
  logic       Gbd_Reading_Ram;
  logic       BlockDone;
  logic [3:0] RoundCount;

  ag32gbd_ram_read_if bus ();

  ag32gbd_ram_read #(.HEAT_UP_CYCLES(10), .READ_WAIT_CYCLES(5)) dut (
    .sys_clock        (sys_clock),
    .sys_resetn       (sys_resetn),
    .NewRunReset      (NewRunReset),
    .BlockReadRequest (BlockReadRequest),
    .Gbd_Reading_Ram  (Gbd_Reading_Ram),
    .bus              (bus),
    .BlockDone        (BlockDone),
    .RoundCount       (RoundCount)
  );

  always #5 sys_clock = ~sys_clock;

  typedef struct packed {
    logic [9:0] off;
    logic [7:0] data;
  } wr_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] img [4096];
  logic [7:0] ram [4096];
  logic [7:0] buf_img [256];
  wr_t        exp_q [$];
  int         ack_delay = 0;
  int         ack_hold = 1;
  int         done_cnt = 0;
  int         wr_cnt = 0;
  int         wb_len = 0;
  int         wb_len_max = 0;
  logic [15:0] rounds_seen = '0;
  logic [11:0] addr_min = 12'hFFF;
  logic [11:0] addr_max = 12'h000;

  // SRAM model: drives data only while selected and output-enabled.
  assign bus.Ram_Reading_Data = (!bus.Ram_Reading_nCS && !bus.Ram_Reading_nOE)
                                ? ram[bus.Ram_Reading_Addr_Low] : 8'h00;

  // Buffer acknowledger with programmable delay and minimum hold.
  initial begin
    bus.BufferWriteAck = 1'b0;
    forever begin
      @(negedge sys_clock);
      if (bus.WriteBuffer && !bus.BufferWriteAck) begin
        repeat (ack_delay) @(negedge sys_clock);
        bus.BufferWriteAck = 1'b1;
        for (int h = 0; (h < ack_hold || bus.WriteBuffer) && h < 1000; h++)
          @(negedge sys_clock);
        bus.BufferWriteAck = 1'b0;
      end
    end
  end

  // Scoreboard monitor: pops on each new write request, checks handshake stability.
  logic        wb_prev = 1'b0;
  logic        in_hs = 1'b0;
  logic [9:0]  hold_off;
  logic [7:0]  hold_data;
  logic [11:0] hold_addr;
  always @(negedge sys_clock) begin
    wr_t e;
    if (BlockDone) done_cnt++;
    if (!bus.Ram_Reading_nCS) begin
      rounds_seen[bus.Ram_Reading_Addr_Low[11:8]] = 1'b1;
      if (bus.Ram_Reading_Addr_Low < addr_min) addr_min = bus.Ram_Reading_Addr_Low;
      if (bus.Ram_Reading_Addr_Low > addr_max) addr_max = bus.Ram_Reading_Addr_Low;
    end
    if (bus.WriteBuffer) wb_len++; else wb_len = 0;
    if (wb_len > wb_len_max) wb_len_max = wb_len;
    if (!Gbd_Reading_Ram) in_hs = 1'b0;
    if (bus.WriteBuffer && !wb_prev) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected off=%h data=%h", bus.WriteBufferOffset, bus.WriteBufferData);
      end else begin
        e = exp_q.pop_front();
        if (bus.WriteBufferOffset !== e.off) begin
          failures++;
          $display("FAIL wr_offset got=%h exp=%h", bus.WriteBufferOffset, e.off);
        end
        checks++;
        if (bus.WriteBufferData !== e.data) begin
          failures++;
          $display("FAIL wr_data off=%h got=%h exp=%h", e.off, bus.WriteBufferData, e.data);
        end
      end
      buf_img[bus.WriteBufferOffset[7:0]] = bus.WriteBufferData;
      hold_off  = bus.WriteBufferOffset;
      hold_data = bus.WriteBufferData;
      hold_addr = bus.Ram_Reading_Addr_Low;
      in_hs     = 1'b1;
    end else if (in_hs) begin
      if (bus.WriteBuffer) begin
        checks++;
        if (bus.WriteBufferOffset !== hold_off || bus.WriteBufferData !== hold_data) begin
          failures++;
          $display("FAIL hs_stable got=%h/%h exp=%h/%h", bus.WriteBufferOffset,
                   bus.WriteBufferData, hold_off, hold_data);
        end
      end
      checks++;
      if (bus.Ram_Reading_Addr_Low !== hold_addr) begin
        failures++;
        $display("FAIL hs_addr got=%h exp=%h", bus.Ram_Reading_Addr_Low, hold_addr);
      end
      if (!bus.WriteBuffer && !bus.BufferWriteAck) in_hs = 1'b0;
    end
    wb_prev = bus.WriteBuffer;
  end

  // SRAM image from buffer images: RAM[2k] even bits, RAM[2k+1] odd bits.
  task automatic encode_ram();
    logic [6:0] k, m;
    logic [7:0] b0, b1, p0, p1;
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 128; i++) begin
        k  = 7'(i);
        m  = {k[2:0], k[6:3]};
        b0 = img[{4'(r), m, 1'b0}];
        b1 = img[{4'(r), m, 1'b1}];
        for (int j = 0; j < 4; j++) begin
          p0[4+j] = b0[2*j];
          p0[j]   = b1[2*j];
          p1[4+j] = b0[2*j+1];
          p1[j]   = b1[2*j+1];
        end
        ram[{4'(r), k, 1'b0}] = p0;
        ram[{4'(r), k, 1'b1}] = p1;
      end
  endtask

  task automatic push_round(input logic [3:0] r);
    wr_t e;
    logic [6:0] k, m;
    for (int i = 0; i < 128; i++) begin
      k = 7'(i);
      m = {k[2:0], k[6:3]};
      for (int b = 0; b < 2; b++) begin
        e.off  = {2'b00, m, 1'(b)};
        e.data = img[{r, m, 1'(b)}];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic trigger();
    @(negedge sys_clock);
    BlockReadRequest = 1'b1;
    repeat (2) @(negedge sys_clock);
    BlockReadRequest = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge sys_clock);
      n++;
    end
    checks++;
    if (done_cnt == base) begin
      failures++;
      $display("FAIL %s_timeout got=no BlockDone exp=BlockDone within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_writes(input int target, input string name);
    int n = 0;
    while (wr_cnt < target && n < 10000) begin
      @(negedge sys_clock);
      n++;
    end
    checks++;
    if (wr_cnt < target) begin
      failures++;
      $display("FAIL %s_wr_timeout got=%0d exp=%0d", name, wr_cnt, target);
    end
  endtask

  task automatic test_reset();
    sys_resetn = 1'b0;
    NewRunReset = 1'b0;
    BlockReadRequest = 1'b0;
    repeat (3) @(negedge sys_clock);
    checks++; if (Gbd_Reading_Ram !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", Gbd_Reading_Ram); end
    checks++; if (bus.Ram_Reading_nCS !== 1'b1) begin failures++; $display("FAIL rst_ncs got=%b exp=1", bus.Ram_Reading_nCS); end
    checks++; if (bus.Ram_Reading_nOE !== 1'b1) begin failures++; $display("FAIL rst_noe got=%b exp=1", bus.Ram_Reading_nOE); end
    checks++; if (bus.Ram_Reading_Addr_Low !== 12'h000) begin failures++; $display("FAIL rst_addr got=%h exp=000", bus.Ram_Reading_Addr_Low); end
    checks++; if (bus.WriteBuffer !== 1'b0) begin failures++; $display("FAIL rst_wb got=%b exp=0", bus.WriteBuffer); end
    checks++; if (bus.WriteBufferOffset !== 10'h000 || bus.WriteBufferData !== 8'h00) begin failures++; $display("FAIL rst_wbuf got=%h/%h exp=000/00", bus.WriteBufferOffset, bus.WriteBufferData); end
    checks++; if (BlockDone !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", BlockDone); end
    checks++; if (RoundCount !== 4'd0) begin failures++; $display("FAIL rst_round got=%0d exp=0", RoundCount); end
    sys_resetn = 1'b1;
  endtask

  task automatic test_first_block();
    int base = done_cnt;
    push_round(4'd0);
    @(negedge sys_clock);
    BlockReadRequest = 1'b1;
    @(negedge sys_clock);
    checks++; if (bus.Ram_Reading_nCS !== 1'b0) begin failures++; $display("FAIL first_ncs got=%b exp=0", bus.Ram_Reading_nCS); end
    checks++; if (Gbd_Reading_Ram !== 1'b1) begin failures++; $display("FAIL first_busy got=%b exp=1", Gbd_Reading_Ram); end
    repeat (HEAT - 1) @(negedge sys_clock);
    checks++; if (bus.Ram_Reading_nOE !== 1'b1) begin failures++; $display("FAIL first_noe_early got=%b exp=1", bus.Ram_Reading_nOE); end
    @(negedge sys_clock);
    checks++; if (bus.Ram_Reading_nOE !== 1'b0) begin failures++; $display("FAIL first_noe got=%b exp=0", bus.Ram_Reading_nOE); end
    BlockReadRequest = 1'b0;
    wait_done(base, 10000, "first");
    @(negedge sys_clock);
    checks++; if (done_cnt !== base + 1) begin failures++; $display("FAIL first_done_cnt got=%0d exp=%0d", done_cnt, base + 1); end
    checks++; if (RoundCount !== 4'd1) begin failures++; $display("FAIL first_round got=%0d exp=1", RoundCount); end
    checks++; if (bus.Ram_Reading_nCS !== 1'b1 || bus.Ram_Reading_nOE !== 1'b1) begin failures++; $display("FAIL first_release got=%b%b exp=11", bus.Ram_Reading_nCS, bus.Ram_Reading_nOE); end
    checks++; if (Gbd_Reading_Ram !== 1'b0) begin failures++; $display("FAIL first_idle got=%b exp=0", Gbd_Reading_Ram); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL first_pending got=%0d exp=0", exp_q.size()); end
    checks++; if (buf_img[0] !== 8'h55) begin failures++; $display("FAIL first_b0 got=%h exp=55", buf_img[0]); end
    checks++; if (buf_img[1] !== 8'hAA) begin failures++; $display("FAIL first_b1 got=%h exp=aa", buf_img[1]); end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (buf_img[i] !== img[i]) begin
        failures++;
        $display("FAIL image off=%h got=%h exp=%h", i, buf_img[i], img[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int base = done_cnt;
    for (int r = 1; r < 16; r++) begin
      push_round(4'(r));
      trigger();
      wait_done(done_cnt, 10000, "wrap");
    end
    @(negedge sys_clock);
    checks++; if (done_cnt !== base + 15) begin failures++; $display("FAIL wrap_done_cnt got=%0d exp=%0d", done_cnt, base + 15); end
    checks++; if (RoundCount !== 4'd0) begin failures++; $display("FAIL wrap_round got=%0d exp=0", RoundCount); end
    checks++; if (rounds_seen !== 16'hFFFF) begin failures++; $display("FAIL wrap_rounds got=%h exp=ffff", rounds_seen); end
    checks++; if (addr_min !== 12'h000 || addr_max !== 12'hFFF) begin failures++; $display("FAIL wrap_span got=%h-%h exp=000-fff", addr_min, addr_max); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_ack_delay();
    int base = done_cnt;
    ack_delay  = 7;
    ack_hold   = 3;
    wb_len_max = 0;
    push_round(4'd0);
    trigger();
    wait_done(base, 20000, "ackdly");
    @(negedge sys_clock);
    checks++; if (wb_len_max != 8) begin failures++; $display("FAIL ackdly_req_len got=%0d exp=8", wb_len_max); end
    checks++; if (RoundCount !== 4'd1) begin failures++; $display("FAIL ackdly_round got=%0d exp=1", RoundCount); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ackdly_pending got=%0d exp=0", exp_q.size()); end
    ack_delay = 0;
    ack_hold  = 1;
  endtask

  task automatic test_busy_edge();
    int base = done_cnt;
    push_round(4'd1);
    trigger();
    wait_writes(wr_cnt + 81, "busy");
    @(negedge sys_clock);
    BlockReadRequest = 1'b1;
    wait_done(base, 10000, "busy");
    repeat (20) @(negedge sys_clock);
    checks++; if (done_cnt !== base + 1) begin failures++; $display("FAIL busy_done_cnt got=%0d exp=%0d", done_cnt, base + 1); end
    checks++; if (Gbd_Reading_Ram !== 1'b0) begin failures++; $display("FAIL busy_requeued got=%b exp=0", Gbd_Reading_Ram); end
    checks++; if (RoundCount !== 4'd2) begin failures++; $display("FAIL busy_round got=%0d exp=2", RoundCount); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL busy_pending got=%0d exp=0", exp_q.size()); end
    BlockReadRequest = 1'b0;
  endtask

  task automatic test_new_run_reset();
    int base;
    push_round(4'd2);
    trigger();
    wait_writes(wr_cnt + 121, "nrr");
    base = done_cnt;
    @(negedge sys_clock);
    NewRunReset = 1'b1;
    BlockReadRequest = 1'b1;
    @(negedge sys_clock);
    checks++; if (Gbd_Reading_Ram !== 1'b0) begin failures++; $display("FAIL nrr_busy got=%b exp=0", Gbd_Reading_Ram); end
    checks++; if (bus.Ram_Reading_nCS !== 1'b1 || bus.Ram_Reading_nOE !== 1'b1) begin failures++; $display("FAIL nrr_release got=%b%b exp=11", bus.Ram_Reading_nCS, bus.Ram_Reading_nOE); end
    checks++; if (bus.WriteBuffer !== 1'b0) begin failures++; $display("FAIL nrr_wb got=%b exp=0", bus.WriteBuffer); end
    checks++; if (RoundCount !== 4'd0) begin failures++; $display("FAIL nrr_round got=%0d exp=0", RoundCount); end
    checks++; if (BlockDone !== 1'b0) begin failures++; $display("FAIL nrr_done got=%b exp=0", BlockDone); end
    NewRunReset = 1'b0;
    exp_q.delete();
    repeat (30) @(negedge sys_clock);
    checks++; if (Gbd_Reading_Ram !== 1'b0) begin failures++; $display("FAIL nrr_trigger_taken got=%b exp=0", Gbd_Reading_Ram); end
    checks++; if (done_cnt !== base) begin failures++; $display("FAIL nrr_done_cnt got=%0d exp=%0d", done_cnt, base); end
    BlockReadRequest = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) img[i] = 8'($urandom);
    img[0] = 8'h55;
    img[1] = 8'hAA;
    encode_ram();
    test_reset();
    test_first_block();
    test_wrap();
    test_ack_delay();
    test_busy_edge();
    test_new_run_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
